// File: rtl/servo_step_discriminator_pkg.sv
// Shared types and helpers for the servo step discriminator: FSM states,
// interrogation side codes and a width-generic saturating adder.
package servo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_LO = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_PULSE   = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_e;

  localparam logic SIDE_LO = 1'b0;
  localparam logic SIDE_HI = 1'b1;

  // Accumulators up to SAT_MAX_W-1 bits wide share one adder description.
  localparam int SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] acc,
                                       input logic [SAT_MAX_W-1:0] inc,
                                       input int unsigned          width);
    sat_res_t             r;
    logic [SAT_MAX_W-1:0] lim;
    logic [SAT_MAX_W-1:0] s;
    lim = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    s   = acc + inc;
    if (s > lim) begin
      r.sum = lim;
      r.ovf = 1'b1;
    end else begin
      r.sum = s;
      r.ovf = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_step_discriminator_if.sv
// Photon-count sample bus from the interrogation sequencer to the discriminator.
interface servo_step_discriminator_if #(
  parameter int CNT_WIDTH = 16
);
  // sample_valid is a one-cycle strobe with no back-pressure: the slave either
  // takes the sample in that cycle or drops it and raises its seq_err flag.
  logic                 sample_valid;
  logic                 sample_side;
  logic [CNT_WIDTH-1:0] sample_count;

  modport master (output sample_valid, output sample_side, output sample_count);
  modport slave  (input  sample_valid, input  sample_side, input  sample_count);
endinterface

// File: rtl/servo_step_discriminator_shaper.sv
// Step pulse shaper: fixed-width step pulse followed by a fixed holdoff with
// both steps low, so the downstream edge-triggered counter never sees a runt.
module step_pulse_shaper #(
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic fire_up,
  input  logic fire_dn,
  output logic step_up,
  output logic step_dn,
  output logic shaper_busy,
  output logic pulse_last,
  output logic hold_last
);

  localparam int MAXC = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_PULSE = 2'd1,
    SH_HOLD  = 2'd2
  } sh_state_e;

  sh_state_e     sh_q;
  logic [TW-1:0] cnt_q;
  logic          up_q;
  logic          dn_q;
  logic          busy_q;

  assign pulse_last  = (sh_q == SH_PULSE) && (cnt_q == TW'(PULSE_CYCLES - 1));
  assign hold_last   = (sh_q == SH_HOLD)  && (cnt_q == TW'(HOLDOFF_CYCLES - 1));
  assign step_up     = up_q;
  assign step_dn     = dn_q;
  assign shaper_busy = busy_q;

  // A request is taken only when idle and only if exactly one direction asks,
  // which is what keeps the two steps mutually exclusive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q   <= SH_IDLE;
      cnt_q  <= '0;
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (sh_q)
        SH_IDLE: begin
          if (fire_up ^ fire_dn) begin
            sh_q   <= SH_PULSE;
            cnt_q  <= '0;
            up_q   <= fire_up;
            dn_q   <= fire_dn;
            busy_q <= 1'b1;
          end
        end
        SH_PULSE: begin
          if (pulse_last) begin
            sh_q  <= SH_HOLD;
            cnt_q <= '0;
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        SH_HOLD: begin
          if (hold_last) begin
            sh_q   <= SH_IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        default: begin
          sh_q   <= SH_IDLE;
          cnt_q  <= '0;
          up_q   <= 1'b0;
          dn_q   <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/servo_step_discriminator.sv
// Servo step discriminator: sums paired low/high interrogation counts, compares
// B-A against a deadband and requests clean up/down steps from the shaper.
module servo_step_discriminator
  import servo_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int ACC_WIDTH      = 24,
  parameter int NAVG_WIDTH     = 8,
  parameter int PULSE_CYCLES   = 4,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  servo_step_discriminator_if.slave smp,
  input  logic [NAVG_WIDTH-1:0]   n_pairs,
  input  logic [ACC_WIDTH-1:0]    deadband,
  output logic                    step_up,
  output logic                    step_dn,
  output logic                    busy,
  output logic                    decision_valid,
  output logic [ACC_WIDTH:0]      error_out,
  output logic                    seq_err,
  output logic                    sat,
  output state_e                  state_dbg
);

  state_e                  state_q, state_d;
  logic [ACC_WIDTH-1:0]    acc_a_q, acc_a_d;
  logic [ACC_WIDTH-1:0]    acc_b_q, acc_b_d;
  logic [NAVG_WIDTH-1:0]   pair_cnt_q, pair_cnt_d;
  logic [NAVG_WIDTH-1:0]   n_pairs_q, n_pairs_d;
  logic [ACC_WIDTH-1:0]    deadband_q, deadband_d;
  logic [ACC_WIDTH:0]      error_q, error_d;
  logic                    dv_q, dv_d;
  logic                    seq_err_q, seq_err_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, busy_d;

  logic [CNT_WIDTH-1:0]    sample_cnt;
  logic [NAVG_WIDTH-1:0]   n_pairs_eff;
  logic [NAVG_WIDTH-1:0]   pair_inc;
  sat_res_t                add_a, add_b;
  logic [ACC_WIDTH-1:0]    acc_a_new, acc_b_new;
  logic [ACC_WIDTH:0]      diff_new;
  logic signed [ACC_WIDTH+1:0] err_ext, db_pos, db_neg;
  logic                    want_up, want_dn;
  logic                    fire_up, fire_dn;
  logic                    shaper_busy, pulse_last, hold_last;

  assign sample_cnt  = smp.sample_count;
  assign n_pairs_eff = (n_pairs == '0) ? NAVG_WIDTH'(1) : n_pairs;
  assign pair_inc    = pair_cnt_q + NAVG_WIDTH'(1);

  always_comb begin
    add_a = sat_add(SAT_MAX_W'(acc_a_q), SAT_MAX_W'(sample_cnt), ACC_WIDTH);
    add_b = sat_add(SAT_MAX_W'(acc_b_q), SAT_MAX_W'(sample_cnt), ACC_WIDTH);
  end

  assign acc_a_new = ACC_WIDTH'(add_a.sum);
  assign acc_b_new = ACC_WIDTH'(add_b.sum);
  // The error is captured on the edge into DECIDE so it is already valid
  // during the decision_valid cycle.
  assign diff_new  = {1'b0, acc_b_new} - {1'b0, acc_a_q};

  // One extra bit of headroom so -deadband never wraps.
  assign err_ext = signed'({error_q[ACC_WIDTH], error_q});
  assign db_pos  = signed'({2'b00, deadband_q});
  assign db_neg  = -db_pos;
  assign want_up = err_ext > db_pos;
  assign want_dn = err_ext < db_neg;
  assign fire_up = (state_q == ST_DECIDE) && want_up;
  assign fire_dn = (state_q == ST_DECIDE) && want_dn;

  always_comb begin
    state_d    = state_q;
    acc_a_d    = acc_a_q;
    acc_b_d    = acc_b_q;
    pair_cnt_d = pair_cnt_q;
    n_pairs_d  = n_pairs_q;
    deadband_d = deadband_q;
    error_d    = error_q;
    dv_d       = 1'b0;
    seq_err_d  = seq_err_q;
    sat_d      = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          n_pairs_d  = n_pairs_eff;
          deadband_d = deadband;
          acc_a_d    = '0;
          acc_b_d    = '0;
          pair_cnt_d = '0;
          seq_err_d  = 1'b0;
          sat_d      = 1'b0;
          state_d    = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO, ST_WAIT_HI: begin
        if (!enable) begin
          acc_a_d    = '0;
          acc_b_d    = '0;
          pair_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (smp.sample_valid) begin
          if (state_q == ST_WAIT_LO && smp.sample_side == SIDE_LO) begin
            acc_a_d = acc_a_new;
            sat_d   = sat_q | add_a.ovf;
            state_d = ST_WAIT_HI;
          end else if (state_q == ST_WAIT_HI && smp.sample_side == SIDE_HI) begin
            acc_b_d    = acc_b_new;
            sat_d      = sat_q | add_b.ovf;
            pair_cnt_d = pair_inc;
            if (pair_inc == n_pairs_q) begin
              error_d = diff_new;
              dv_d    = 1'b1;
              state_d = ST_DECIDE;
            end else begin
              state_d = ST_WAIT_LO;
            end
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end
      ST_DECIDE: begin
        if (smp.sample_valid) seq_err_d = 1'b1;
        acc_a_d    = '0;
        acc_b_d    = '0;
        pair_cnt_d = '0;
        n_pairs_d  = n_pairs_eff;
        deadband_d = deadband;
        if (want_up || want_dn) state_d = ST_PULSE;
        else                    state_d = enable ? ST_WAIT_LO : ST_IDLE;
      end
      ST_PULSE: begin
        if (smp.sample_valid) seq_err_d = 1'b1;
        if (pulse_last || !shaper_busy) state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (smp.sample_valid) seq_err_d = 1'b1;
        if (hold_last || !shaper_busy) state_d = enable ? ST_WAIT_LO : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_DECIDE) || (state_d == ST_PULSE) || (state_d == ST_HOLDOFF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      acc_a_q    <= '0;
      acc_b_q    <= '0;
      pair_cnt_q <= '0;
      n_pairs_q  <= '0;
      deadband_q <= '0;
      error_q    <= '0;
      dv_q       <= 1'b0;
      seq_err_q  <= 1'b0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_a_q    <= acc_a_d;
      acc_b_q    <= acc_b_d;
      pair_cnt_q <= pair_cnt_d;
      n_pairs_q  <= n_pairs_d;
      deadband_q <= deadband_d;
      error_q    <= error_d;
      dv_q       <= dv_d;
      seq_err_q  <= seq_err_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
    end
  end

  step_pulse_shaper #(
    .PULSE_CYCLES   (PULSE_CYCLES),
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
  ) u_shaper (
    .clk         (clk),
    .reset_n     (reset_n),
    .fire_up     (fire_up),
    .fire_dn     (fire_dn),
    .step_up     (step_up),
    .step_dn     (step_dn),
    .shaper_busy (shaper_busy),
    .pulse_last  (pulse_last),
    .hold_last   (hold_last)
  );

  assign busy           = busy_q;
  assign decision_valid = dv_q;
  assign error_out      = error_q;
  assign seq_err        = seq_err_q;
  assign sat            = sat_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_servo_step_discriminator.sv
// Bench for servo_step_discriminator: directed scenarios plus randomized pairs,
// checked against a sum-and-compare model with a queue of expected errors.
module tb_servo_step_discriminator;
  import servo_pkg::*;

  localparam int CNT_W = 16;
  localparam int ACC_W = 17;
  localparam int NAV_W = 8;
  localparam int PULSE = 4;
  localparam int HOLD  = 4;
  localparam int MAXV  = (1 << ACC_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [NAV_W-1:0]  n_pairs = '0;
  logic [ACC_W-1:0]  deadband = '0;
  logic              step_up, step_dn, busy, decision_valid, seq_err, sat;
  logic [ACC_W:0]    error_out;
  state_e            state_dbg;

  servo_step_discriminator_if #(.CNT_WIDTH(CNT_W)) sif ();

  servo_step_discriminator #(
    .CNT_WIDTH      (CNT_W),
    .ACC_WIDTH      (ACC_W),
    .NAVG_WIDTH     (NAV_W),
    .PULSE_CYCLES   (PULSE),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .smp            (sif),
    .n_pairs        (n_pairs),
    .deadband       (deadband),
    .step_up        (step_up),
    .step_dn        (step_dn),
    .busy           (busy),
    .decision_valid (decision_valid),
    .error_out      (error_out),
    .seq_err        (seq_err),
    .sat            (sat),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int             n_tests = 0;
  int             n_fail  = 0;
  logic [ACC_W:0] exp_q[$];
  int             dir_q[$];
  int             lo_v[256];
  int             hi_v[256];
  int             cur_np, cur_db;
  logic           exp_sat = 1'b0;
  logic           exp_seq = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int acc_add(input int a, input int c);
    if (a + c > MAXV) begin
      exp_sat = 1'b1;
      return MAXV;
    end
    return a + c;
  endfunction

  // Output monitor: decisions, step direction/timing, widths, gaps, exclusion.
  int rise_chk = 0;
  int up_hi = 0;
  int dn_hi = 0;
  int low_run = 0;
  bit seen_pulse = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      rise_chk = 0; up_hi = 0; dn_hi = 0; low_run = 0; seen_pulse = 1'b0;
    end else begin
      if (rise_chk != 0) begin
        chk("step_up_after_decision", step_up, rise_chk == 1);
        chk("step_dn_after_decision", step_dn, rise_chk == 2);
        rise_chk = 0;
      end
      if (decision_valid) begin
        if (exp_q.size() == 0) chk("unexpected_decision", 1, 0);
        else begin
          chk("error_out", error_out, exp_q.pop_front());
          rise_chk = dir_q.pop_front();
          if (rise_chk == 0) rise_chk = 3;
        end
      end
      if (step_up || step_dn) chk("step_mutex", step_up & step_dn, 0);
      if (step_up) up_hi++;
      else if (up_hi != 0) begin chk("step_up_width", up_hi, PULSE); up_hi = 0; end
      if (step_dn) dn_hi++;
      else if (dn_hi != 0) begin chk("step_dn_width", dn_hi, PULSE); dn_hi = 0; end
      if (step_up || step_dn) begin
        if (up_hi + dn_hi == 1 && seen_pulse) chk("holdoff_gap", low_run >= HOLD, 1);
        low_run = 0;
        seen_pulse = 1'b1;
      end else begin
        low_run++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_sample(input logic side, input int cnt);
    sif.sample_valid = 1'b1;
    sif.sample_side  = side;
    sif.sample_count = cnt[CNT_W-1:0];
    cyc(1);
    sif.sample_valid = 1'b0;
  endtask

  task automatic do_pairs(input int np, input int db, input int gap_max);
    int a = 0;
    int b = 0;
    int diff, np_eff;
    logic [ACC_W:0] d;
    np_eff = (np == 0) ? 1 : np;
    for (int i = 0; i < np_eff; i++) begin
      a = acc_add(a, lo_v[i]);
      b = acc_add(b, hi_v[i]);
    end
    diff = b - a;
    d = diff[ACC_W:0];
    exp_q.push_back(d);
    dir_q.push_back(diff > db ? 1 : (diff < -db ? 2 : 0));
    for (int i = 0; i < np_eff; i++) begin
      drive_sample(SIDE_LO, lo_v[i]);
      cyc($urandom_range(0, gap_max));
      drive_sample(SIDE_HI, hi_v[i]);
      if (i < np_eff - 1) cyc($urandom_range(0, gap_max));
    end
    chk("decision_latency", decision_valid, 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 100) begin cyc(1); n++; end
    chk("busy_release", busy, 0);
  endtask

  task automatic go_idle();
    int n = 0;
    enable = 1'b0;
    while (state_dbg != ST_IDLE && n < 100) begin cyc(1); n++; end
    chk("reach_idle", state_dbg == ST_IDLE, 1);
  endtask

  task automatic start(input int np, input int db);
    n_pairs  = np[NAV_W-1:0];
    deadband = db[ACC_W-1:0];
    cur_np   = np;
    cur_db   = db;
    exp_sat  = 1'b0;
    exp_seq  = 1'b0;
    enable   = 1'b1;
    cyc(1);
    chk("start_state", state_dbg, ST_WAIT_LO);
    chk("start_seq_err_clear", seq_err, 0);
    chk("start_sat_clear", sat, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    sif.sample_valid = 1'b0;
    sif.sample_side  = 1'b0;
    sif.sample_count = '0;
    cyc(3);
    chk("reset_state", state_dbg, ST_IDLE);
    chk("reset_outputs", {step_up, step_dn, busy, decision_valid, seq_err, sat}, 0);
    chk("reset_error_out", error_out, 0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_ignores_samples_state", state_dbg, ST_IDLE);

    // up step over two pairs
    start(2, 10);
    lo_v[0] = 100; hi_v[0] = 120; lo_v[1] = 100; hi_v[1] = 110;
    do_pairs(2, 10, 1);
    wait_ready();
    chk("up_no_seq_err", seq_err, 0);

    // deadband edge then down step
    go_idle();
    start(1, 10);
    lo_v[0] = 200; hi_v[0] = 190;
    do_pairs(1, 10, 0);
    wait_ready();
    chk("edge_back_to_wait_lo", state_dbg, ST_WAIT_LO);
    lo_v[0] = 200; hi_v[0] = 189;
    do_pairs(1, 10, 0);
    wait_ready();

    // sequencing errors
    go_idle();
    start(1, 10);
    drive_sample(SIDE_HI, 500);
    exp_seq = 1'b1;
    chk("seq_err_hi_in_wait_lo", seq_err, exp_seq);
    chk("seq_state_stays_wait_lo", state_dbg, ST_WAIT_LO);
    lo_v[0] = 0; hi_v[0] = 100;
    do_pairs(1, 10, 1);
    cyc(1);
    chk("in_pulse", state_dbg, ST_PULSE);
    drive_sample(SIDE_LO, 777);
    chk("seq_err_during_pulse", seq_err, exp_seq);
    wait_ready();
    lo_v[0] = 10; hi_v[0] = 10;
    do_pairs(1, 10, 0);
    wait_ready();
    go_idle();
    start(1, 10);

    // saturation of the high-side sum
    go_idle();
    start(4, 0);
    for (int i = 0; i < 4; i++) begin lo_v[i] = 0; hi_v[i] = 65535; end
    do_pairs(4, 0, 1);
    wait_ready();
    chk("sat_flag", sat, exp_sat);

    // enable dropped mid-pulse: pulse and holdoff complete, then idle
    go_idle();
    start(1, 0);
    lo_v[0] = 0; hi_v[0] = 50;
    do_pairs(1, 0, 0);
    cyc(1);
    enable = 1'b0;
    n = 0;
    while (state_dbg != ST_IDLE && n < 50) begin cyc(1); n++; end
    chk("en_low_pulse_then_idle_cycles", n, PULSE + HOLD);

    // enable dropped in WAIT_HI
    start(1, 0);
    drive_sample(SIDE_LO, 5);
    chk("in_wait_hi", state_dbg, ST_WAIT_HI);
    enable = 1'b0;
    cyc(1);
    chk("en_low_wait_hi_idle", state_dbg, ST_IDLE);
    cyc(3);
    chk("en_low_wait_hi_no_step", {step_up, step_dn}, 0);

    // asynchronous reset mid-pulse
    start(1, 0);
    lo_v[0] = 0; hi_v[0] = 80;
    do_pairs(1, 0, 0);
    cyc(2);
    chk("pulse_before_reset", step_up, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_async_step_up", step_up, 0);
    chk("reset_async_outputs", {step_dn, busy, decision_valid, seq_err, sat}, 0);
    chk("reset_async_state", state_dbg, ST_IDLE);
    exp_q.delete();
    dir_q.delete();
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    start(0, 5);
    lo_v[0] = 10; hi_v[0] = 20;
    do_pairs(0, 5, 0);
    wait_ready();

    // randomized decisions with parameters re-latched after each one
    go_idle();
    start($urandom_range(0, 3), $urandom_range(0, 3000));
    for (int t = 0; t < 30; t++) begin
      int np_e;
      np_e = (cur_np == 0) ? 1 : cur_np;
      for (int i = 0; i < np_e; i++) begin
        int base, off, h;
        base = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535))
                                            : int'($urandom_range(0, 2000));
        off  = int'($urandom_range(0, 3000)) - 1500;
        h    = base + off;
        if (h < 0) h = 0;
        if (h > 65535) h = 65535;
        lo_v[i] = base;
        hi_v[i] = h;
      end
      do_pairs(cur_np, cur_db, 2);
      cur_np   = $urandom_range(0, 3);
      cur_db   = $urandom_range(0, 3000);
      n_pairs  = cur_np[NAV_W-1:0];
      deadband = cur_db[ACC_W-1:0];
      wait_ready();
      chk("rand_sat", sat, exp_sat);
      chk("rand_seq_err", seq_err, exp_seq);
    end

    go_idle();
    cyc(5);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_step_discriminator.md
Name: servo_step_discriminator

Overview:
- Upstream stage of the servo frequency-step up/down counter.
- Accumulates photon-count samples from paired low-side and high-side interrogations over a programmable number of pairs.
- Compares the two sums against a deadband and emits clean, mutually exclusive step_up / step_dn pulses.
- The downstream counter is edge-triggered on these pulses, so this block guarantees minimum pulse width and minimum gap between pulses.

Parameters:
- CNT_WIDTH, 16: width of one photon-count sample.
- ACC_WIDTH, 24: width of each side accumulator, which saturates.
- NAVG_WIDTH, 8: width of the n_pairs input.
- PULSE_CYCLES, 4: clk cycles a step output stays high (>=1).
- HOLDOFF_CYCLES, 4: clk cycles with both steps low after a pulse (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run servo; low = finish current action, then idle.
- sample_valid  in  1  single-cycle strobe, sample present.
- sample_side  in  1  0 = low-side interrogation, 1 = high-side.
- sample_count  in  CNT_WIDTH  photon count for this interrogation.
- n_pairs  in  NAVG_WIDTH  pairs per decision; 0 treated as 1.
- deadband  in  ACC_WIDTH  unsigned threshold on |B-A|.
- step_up  out  1  pulse to counter clk_up.
- step_dn  out  1  pulse to counter clk_dn.
- busy  out  1  high in DECIDE/PULSE/HOLDOFF; samples ignored.
- decision_valid  out  1  single-cycle strobe, error_out updated.
- error_out  out  ACC_WIDTH+1  signed B-A of last decision.
- seq_err  out  1  sticky: out-of-order or dropped sample.
- sat  out  1  sticky: an accumulator saturated.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low (reset_n).
- Reset values:
  - All outputs 0; state IDLE; accumulators A, B = 0; pair counter = 0.
  - Steps drop immediately on reset assertion, even mid-pulse.
- States: IDLE, WAIT_LO, WAIT_HI, DECIDE, PULSE, HOLDOFF.
- IDLE:
  - On enable=1, latch n_pairs (0 becomes 1) and deadband, clear A/B/pair counter, go to WAIT_LO.
  - Inputs are otherwise ignored.
- WAIT_LO:
  - sample_valid with side=0: A <= sat(A + sample_count), go to WAIT_HI.
  - sample_valid with side=1: sample dropped, seq_err <= 1, stay.
- WAIT_HI:
  - sample_valid with side=1: B <= sat(B + sample_count), pair counter +1.
  - Then go to DECIDE if count == latched n_pairs, else WAIT_LO.
  - sample_valid with side=0: sample dropped, seq_err <= 1, stay.
- Saturation: on a carry out, the accumulator clamps to all-ones and sat <= 1.
- DECIDE (exactly 1 cycle):
  - diff = B - A, computed signed at ACC_WIDTH+1 bits; error_out <= diff; decision_valid = 1 this cycle.
  - diff > deadband: step_up branch. diff < -deadband: step_dn branch. Otherwise (including equality to ±deadband): no step.
  - Step branch goes to PULSE; no-step goes to WAIT_LO (or IDLE if enable=0).
  - Leaving DECIDE clears A, B and the pair counter, and re-latches n_pairs and deadband.
- PULSE: the selected step is registered high for exactly PULSE_CYCLES, then HOLDOFF.
- HOLDOFF:
  - Both steps low for HOLDOFF_CYCLES, then WAIT_LO (enable=1) or IDLE.
- Step invariants: step_up and step_dn are never high together; both are glitch-free register outputs.
- Latency: last high-side sample accepted at cycle k, decision_valid at k+1, step rising at k+2.
- busy / dropped samples: sample_valid while busy=1 is dropped and sets seq_err.
- enable deassertion:
  - Taken immediately in WAIT_LO/WAIT_HI (partial sums discarded, go to IDLE).
  - An in-progress PULSE and HOLDOFF always complete; pulses are never truncated.
- Sticky flags: seq_err and sat clear only on reset or on the IDLE→WAIT_LO transition.

Decomposition:
- Shared package servo_pkg:
  - State enum.
  - SIDE_LO = 0, SIDE_HI = 1.
  - Function sat_add(acc, inc) returning the clamped sum plus an overflow bit.
- Sub-module step_pulse_shaper:
  - Inputs: fire_up, fire_dn.
  - Implements the PULSE/HOLDOFF timer and the mutual-exclusion guarantee.
  - Outputs: step_up, step_dn, shaper_busy.

Test Plan:
- Up step: n_pairs=2, deadband=10; pairs (lo 100, hi 120), (lo 100, hi 110) → error_out=+30; step_up high 4 cycles starting 2 cycles after the last sample; step_dn stays 0.
- Down step and deadband edge: n_pairs=1, deadband=10; (lo 200, hi 190) → error_out=-10, no step; then (lo 200, hi 189) → error_out=-11, step_dn 4 cycles.
- Sequencing: hi sample in WAIT_LO → seq_err=1, sum unaffected; a sample during PULSE is dropped and seq_err stays 1; next enable rise from IDLE clears seq_err.
- Saturation: CNT_WIDTH=16, ACC_WIDTH=17, n_pairs=4, hi samples all 0xFFFF, lo 0 → B clamps at 0x1FFFF, sat=1, step_up fires.
- enable low mid-PULSE → pulse still lasts 4 cycles, holdoff 4 cycles, then IDLE. enable low in WAIT_HI → IDLE next cycle, no step.
- Reset mid-PULSE: reset_n low for 1 cycle during step_up → step_up low asynchronously, all outputs 0, state IDLE; n_pairs=0 afterwards behaves as 1.
